// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX/MEM register, data memory, branch resolve, MEM/WB register
module mem_stage #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              flush,
    input  logic              RegWrite_EX,
    input  logic              Mem2Reg_EX,
    input  logic              MemWrite_EX,
    input  logic              MemRead_EX,
    input  logic              Branch_EX,
    input  logic              zero_EX,
    input  logic [31:0]       ALU_result_EX,
    input  logic [31:0]       store_data_EX,
    input  logic [4:0]        reg_write_EX,
    input  logic [7:0]        branch_target_EX,
    output logic              PCSrc,
    output logic [7:0]        branch_target_MEM,
    output logic              RegWrite_WB,
    output logic              Mem2Reg_WB,
    output logic [31:0]       read_data_WB,
    output logic [31:0]       ALU_result_WB,
    output logic [4:0]        reg_write_WB,
    output logic [31:0]       wb_data,
    output logic              mem_exception,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    // EX/MEM pipeline register
    logic        regwrite_mem_q, mem2reg_mem_q, memwrite_mem_q, memread_mem_q;
    logic        branch_mem_q, zero_mem_q;
    logic [31:0] alu_mem_q, store_data_mem_q;
    logic [4:0]  rd_mem_q;
    logic [7:0]  bt_mem_q;

    // MEM/WB pipeline register
    logic        regwrite_wb_q, mem2reg_wb_q, mem_exc_q;
    logic [31:0] read_data_wb_q, alu_wb_q;
    logic [4:0]  rd_wb_q;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned, out_of_range, bad_access, mem_we;
    logic [31:0]       read_data_d;
    logic              regwrite_wb_d, mem_exc_d;

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            regwrite_mem_q   <= 1'b0;
            mem2reg_mem_q    <= 1'b0;
            memwrite_mem_q   <= 1'b0;
            memread_mem_q    <= 1'b0;
            branch_mem_q     <= 1'b0;
            zero_mem_q       <= 1'b0;
            alu_mem_q        <= '0;
            store_data_mem_q <= '0;
            rd_mem_q         <= '0;
            bt_mem_q         <= '0;
        end else begin
            // A flush turns the slot into a bubble: controls drop, data rides along harmlessly
            regwrite_mem_q   <= RegWrite_EX & ~flush;
            mem2reg_mem_q    <= Mem2Reg_EX  & ~flush;
            memwrite_mem_q   <= MemWrite_EX & ~flush;
            memread_mem_q    <= MemRead_EX  & ~flush;
            branch_mem_q     <= Branch_EX   & ~flush;
            zero_mem_q       <= zero_EX;
            alu_mem_q        <= ALU_result_EX;
            store_data_mem_q <= store_data_EX;
            rd_mem_q         <= reg_write_EX;
            bt_mem_q         <= branch_target_EX;
        end
    end

    always_comb begin
        word_idx      = alu_mem_q[ADDR_W+1:2];
        misaligned    = |alu_mem_q[1:0];
        out_of_range  = |alu_mem_q[31:ADDR_W+2];
        bad_access    = (memread_mem_q | memwrite_mem_q) & (misaligned | out_of_range);
        mem_we        = memwrite_mem_q & ~bad_access;
        // Read sees the word before any same-edge store lands
        read_data_d   = bad_access ? 32'd0 : mem_q[word_idx];
        regwrite_wb_d = regwrite_mem_q & ~bad_access;
        mem_exc_d     = mem_exc_q | bad_access;
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge SYS_clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= store_data_mem_q;
        end
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            regwrite_wb_q  <= 1'b0;
            mem2reg_wb_q   <= 1'b0;
            read_data_wb_q <= '0;
            alu_wb_q       <= '0;
            rd_wb_q        <= '0;
            mem_exc_q      <= 1'b0;
        end else begin
            regwrite_wb_q  <= regwrite_wb_d;
            mem2reg_wb_q   <= mem2reg_mem_q;
            read_data_wb_q <= read_data_d;
            alu_wb_q       <= alu_mem_q;
            rd_wb_q        <= rd_mem_q;
            mem_exc_q      <= mem_exc_d;
        end
    end

    assign PCSrc             = branch_mem_q & zero_mem_q;
    assign branch_target_MEM = bt_mem_q;
    assign RegWrite_WB       = regwrite_wb_q;
    assign Mem2Reg_WB        = mem2reg_wb_q;
    assign read_data_WB      = read_data_wb_q;
    assign ALU_result_WB     = alu_wb_q;
    assign reg_write_WB      = rd_wb_q;
    assign wb_data           = mem2reg_wb_q ? read_data_wb_q : alu_wb_q;
    assign mem_exception     = mem_exc_q;
    assign dbg_data          = mem_q[dbg_addr];

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level model
`timescale 1ns/1ps
module tb_mem_stage;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        flush, RegWrite_EX, Mem2Reg_EX, MemWrite_EX, MemRead_EX, Branch_EX, zero_EX;
    logic [31:0] ALU_result_EX, store_data_EX;
    logic [4:0]  reg_write_EX;
    logic [7:0]  branch_target_EX;
    logic        PCSrc, RegWrite_WB, Mem2Reg_WB, mem_exception;
    logic [7:0]  branch_target_MEM;
    logic [31:0] read_data_WB, ALU_result_WB, wb_data, dbg_data;
    logic [4:0]  reg_write_WB;
    logic [5:0]  dbg_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 SYS_clk = ~SYS_clk;

    mem_stage #(.DEPTH(64), .ADDR_W(6)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .flush(flush),
        .RegWrite_EX(RegWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .MemWrite_EX(MemWrite_EX),
        .MemRead_EX(MemRead_EX), .Branch_EX(Branch_EX), .zero_EX(zero_EX),
        .ALU_result_EX(ALU_result_EX), .store_data_EX(store_data_EX),
        .reg_write_EX(reg_write_EX), .branch_target_EX(branch_target_EX),
        .PCSrc(PCSrc), .branch_target_MEM(branch_target_MEM),
        .RegWrite_WB(RegWrite_WB), .Mem2Reg_WB(Mem2Reg_WB), .read_data_WB(read_data_WB),
        .ALU_result_WB(ALU_result_WB), .reg_write_WB(reg_write_WB), .wb_data(wb_data),
        .mem_exception(mem_exception), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct packed {
        logic        rw, m2r, mw, mr, br, z;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
        logic [7:0]  bt;
        logic        fl;
    } txn_t;

    // Reference model: memory image, the instruction sitting in MEM, and expected WB fields
    logic [31:0] mem_m [64];
    txn_t        ms;
    logic        exp_rw, exp_m2r, exp_mex;
    logic [31:0] exp_rdata, exp_alu;
    logic [4:0]  exp_rdx;

    function automatic txn_t mk(input logic rw, m2r, mw, mr, br, z,
                                input logic [31:0] alu, sd, input logic [4:0] rd,
                                input logic [7:0] bt, input logic fl);
        txn_t t;
        t.rw = rw; t.m2r = m2r; t.mw = mw; t.mr = mr; t.br = br; t.z = z;
        t.alu = alu; t.sd = sd; t.rd = rd; t.bt = bt; t.fl = fl;
        return t;
    endfunction

    function automatic txn_t idle();
        return mk(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 8'd0, 0);
    endfunction

    task automatic model_reset();
        ms = idle(); exp_rw = 0; exp_m2r = 0; exp_mex = 0;
        exp_rdata = 0; exp_alu = 0; exp_rdx = 0;
    endtask

    // Present t to EX, advance one edge, advance the model; returns 1ns after the edge
    task automatic cycle(input txn_t t);
        logic [31:0] a;
        logic        bad;
        int          idx;
        flush = t.fl; RegWrite_EX = t.rw; Mem2Reg_EX = t.m2r; MemWrite_EX = t.mw;
        MemRead_EX = t.mr; Branch_EX = t.br; zero_EX = t.z; ALU_result_EX = t.alu;
        store_data_EX = t.sd; reg_write_EX = t.rd; branch_target_EX = t.bt;
        @(posedge SYS_clk);
        a   = ms.alu;
        bad = (ms.mr || ms.mw) && ((a % 4) != 0 || (a / 4) >= 64);
        idx = int'((a / 4) % 64);
        exp_rdata = bad ? 32'd0 : mem_m[idx];
        if (ms.mw && !bad) mem_m[idx] = ms.sd;
        exp_rw  = ms.rw && !bad;
        exp_m2r = ms.m2r;
        exp_alu = ms.alu;
        exp_rdx = ms.rd;
        exp_mex = exp_mex || bad;
        ms = t;
        if (t.fl) begin
            ms.rw = 0; ms.m2r = 0; ms.mw = 0; ms.mr = 0; ms.br = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        cycle_inputs_idle();
        SYS_reset = 1'b1;
        #2;
        SYS_reset = 1'b0;
        model_reset();
    endtask

    task automatic cycle_inputs_idle();
        flush = 0; RegWrite_EX = 0; Mem2Reg_EX = 0; MemWrite_EX = 0; MemRead_EX = 0;
        Branch_EX = 0; zero_EX = 0; ALU_result_EX = 0; store_data_EX = 0;
        reg_write_EX = 0; branch_target_EX = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({PCSrc, branch_target_MEM, RegWrite_WB, Mem2Reg_WB, read_data_WB, ALU_result_WB,
             reg_write_WB, wb_data, mem_exception} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got PCSrc=%b bt=%h rw=%b m2r=%b rd=%h alu=%h rdx=%h wb=%h exc=%b, want all 0",
                     PCSrc, branch_target_MEM, RegWrite_WB, Mem2Reg_WB, read_data_WB,
                     ALU_result_WB, reg_write_WB, wb_data, mem_exception);
        end
    endtask

    task automatic test_init_mem();
        for (int i = 0; i < 64; i++)
            cycle(mk(0, 0, 1, 0, 0, 0, 32'(i * 4), $urandom, 5'd0, 8'd0, 0));
        for (int i = 0; i < 64; i++) begin
            dbg_addr = 6'(i);
            cycle(idle());
            n_checks++;
            if (dbg_data !== mem_m[i]) begin
                n_fail++;
                $display("FAIL init_mem[%0d]: got %h want %h", i, dbg_data, mem_m[i]);
            end
        end
    endtask

    task automatic test_store_load();
        cycle(mk(0, 0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 8'd0, 0));
        cycle(mk(1, 1, 0, 1, 0, 0, 32'h10, 32'd0, 5'd5, 8'd0, 0));
        dbg_addr = 6'd4;
        cycle(idle());
        n_checks++;
        if (wb_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL st_ld_wb_data: got %h want deadbeef", wb_data);
        end
        n_checks++;
        if ({RegWrite_WB, reg_write_WB} !== {1'b1, 5'd5}) begin
            n_fail++; $display("FAIL st_ld_rw: got rw=%b rd=%0d want rw=1 rd=5", RegWrite_WB, reg_write_WB);
        end
        n_checks++;
        if (dbg_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL st_ld_dbg: got %h want deadbeef", dbg_data);
        end
    endtask

    task automatic test_misaligned();
        cycle(mk(1, 1, 0, 1, 0, 0, 32'h13, 32'd0, 5'd7, 8'd0, 0));
        cycle(idle());
        n_checks++;
        if ({RegWrite_WB, read_data_WB, mem_exception} !== {1'b0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL misaligned: got rw=%b rdata=%h exc=%b want rw=0 rdata=0 exc=1",
                     RegWrite_WB, read_data_WB, mem_exception);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(idle());
            n_checks++;
            if (mem_exception !== 1'b1) begin
                n_fail++; $display("FAIL exc_sticky[%0d]: got %b want 1", i, mem_exception);
            end
        end
        apply_reset();
        n_checks++;
        if (mem_exception !== 1'b0) begin
            n_fail++; $display("FAIL exc_reset: got %b want 0", mem_exception);
        end
        cycle(idle());
    endtask

    task automatic test_out_of_range();
        cycle(mk(0, 0, 1, 0, 0, 0, 32'h100, 32'hA5A5_5A5A, 5'd0, 8'd0, 0));
        cycle(idle());
        n_checks++;
        if (mem_exception !== 1'b1) begin
            n_fail++; $display("FAIL oor_exc: got %b want 1", mem_exception);
        end
        for (int i = 0; i < 64; i++) begin
            dbg_addr = 6'(i);
            cycle(idle());
            n_checks++;
            if (dbg_data !== mem_m[i]) begin
                n_fail++; $display("FAIL oor_mem[%0d]: got %h want %h", i, dbg_data, mem_m[i]);
            end
        end
        apply_reset();
        cycle(idle());
    endtask

    task automatic test_branch();
        cycle(mk(0, 0, 0, 0, 1, 1, 32'd0, 32'd0, 5'd0, 8'h2A, 0));
        n_checks++;
        if ({PCSrc, branch_target_MEM} !== {1'b1, 8'h2A}) begin
            n_fail++; $display("FAIL branch_taken: got pcsrc=%b bt=%h want 1 2a", PCSrc, branch_target_MEM);
        end
        cycle(mk(0, 0, 0, 0, 1, 0, 32'd0, 32'd0, 5'd0, 8'h2A, 0));
        n_checks++;
        if ({PCSrc, branch_target_MEM} !== {1'b0, 8'h2A}) begin
            n_fail++; $display("FAIL branch_not_taken: got pcsrc=%b bt=%h want 0 2a", PCSrc, branch_target_MEM);
        end
    endtask

    task automatic test_flush();
        logic [31:0] old2;
        old2 = mem_m[2];
        dbg_addr = 6'd2;
        cycle(mk(1, 0, 1, 0, 0, 0, 32'h08, ~old2, 5'd9, 8'd0, 1));
        cycle(idle());
        n_checks++;
        if (dbg_data !== old2) begin
            n_fail++; $display("FAIL flush_mem: got %h want %h", dbg_data, old2);
        end
        n_checks++;
        if (RegWrite_WB !== 1'b0) begin
            n_fail++; $display("FAIL flush_rw: got %b want 0", RegWrite_WB);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] old3;
        old3 = mem_m[3];
        cycle(mk(1, 0, 0, 0, 0, 0, 32'h44, 32'd0, 5'd3, 8'd0, 0));
        cycle(mk(1, 0, 1, 0, 1, 1, 32'h0C, ~old3, 5'd4, 8'h55, 0));
        cycle_inputs_idle();
        SYS_reset = 1'b1;
        #1;
        test_reset();
        #1;
        SYS_reset = 1'b0;
        model_reset();
        dbg_addr = 6'd3;
        cycle(idle());
        n_checks++;
        if (dbg_data !== old3) begin
            n_fail++; $display("FAIL reset_store_dropped: got %h want %h", dbg_data, old3);
        end
    endtask

    task automatic test_random();
        txn_t        t;
        logic [31:0] a, exp_wb;
        int          r;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) apply_reset();
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 63) * 4);
            else if (r == 8) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else             a = $urandom | 32'h100;
            t = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), a, $urandom, 5'($urandom), 8'($urandom),
                   $urandom_range(0, 7) == 0);
            dbg_addr = 6'($urandom_range(0, 63));
            cycle(t);
            exp_wb = exp_m2r ? exp_rdata : exp_alu;
            n_checks++;
            if ({PCSrc, branch_target_MEM, RegWrite_WB, Mem2Reg_WB, read_data_WB, ALU_result_WB,
                 reg_write_WB, wb_data, mem_exception} !==
                {ms.br & ms.z, ms.bt, exp_rw, exp_m2r, exp_rdata, exp_alu, exp_rdx, exp_wb, exp_mex}) begin
                n_fail++;
                $display("FAIL random[%0d]: got pcsrc=%b bt=%h rw=%b m2r=%b rdata=%h alu=%h rd=%h wb=%h exc=%b want pcsrc=%b bt=%h rw=%b m2r=%b rdata=%h alu=%h rd=%h wb=%h exc=%b",
                         i, PCSrc, branch_target_MEM, RegWrite_WB, Mem2Reg_WB, read_data_WB,
                         ALU_result_WB, reg_write_WB, wb_data, mem_exception,
                         ms.br & ms.z, ms.bt, exp_rw, exp_m2r, exp_rdata, exp_alu, exp_rdx, exp_wb, exp_mex);
            end
            n_checks++;
            if (dbg_data !== mem_m[dbg_addr]) begin
                n_fail++; $display("FAIL random_dbg[%0d]: got %h want %h", i, dbg_data, mem_m[dbg_addr]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SYS_reset = 1'b1;
        dbg_addr  = '0;
        cycle_inputs_idle();
        model_reset();
        repeat (2) @(posedge SYS_clk);
        #1;
        test_reset();
        SYS_reset = 1'b0;
        test_init_mem();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_branch();
        test_flush();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
